// File: rtl/demultiplexer_16_reg_pkg.sv
// Shared widths and select encodings for the 16-bit demux/mux pair.
// Imported by the demultiplexer top and its output slot.
package demultiplexer_16_reg_pkg;

   localparam int WIDTH_DEF     = 16;
   localparam int CNT_WIDTH_DEF = 8;

   localparam logic SEL_OUT1 = 1'b0;
   localparam logic SEL_OUT2 = 1'b1;

endpackage

// File: rtl/demultiplexer_16_reg_out_slot_16.sv
// One-entry output holding register with valid/ready and a
// wrapping count of completed output handshakes.
module out_slot_16
   import demultiplexer_16_reg_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [WIDTH-1:0]     din,
   output logic                 can_take,
   output logic [WIDTH-1:0]     data,
   output logic                 valid,
   input  logic                 ready,
   output logic [CNT_WIDTH-1:0] count
);

   logic drain;

   assign drain    = valid & ready;
   assign can_take = ~valid | ready;

   // A load in the drain cycle keeps the slot full.
   always_ff @(posedge clk) begin
      if (reset) begin
         data  <= '0;
         valid <= 1'b0;
         count <= '0;
      end else begin
         if (drain) begin
            count <= count + 1'b1;
         end
         if (load) begin
            data  <= din;
            valid <= 1'b1;
         end else if (drain) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/demultiplexer_16_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to
// one of two independently back-pressured output slots.
module demultiplexer_16_reg
   import demultiplexer_16_reg_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     myIn,
   input  logic                 select,
   input  logic                 inValid,
   output logic                 inReady,
   output logic [WIDTH-1:0]     myOut1,
   output logic                 out1Valid,
   input  logic                 out1Ready,
   output logic [WIDTH-1:0]     myOut2,
   output logic                 out2Valid,
   input  logic                 out2Ready,
   output logic [CNT_WIDTH-1:0] count1,
   output logic [CNT_WIDTH-1:0] count2
);

   logic take1;
   logic take2;
   logic load1;
   logic load2;
   logic xfer;

   // inReady depends only on select and the chosen slot.
   assign inReady = (select == SEL_OUT2) ? take2 : take1;
   assign xfer    = inValid & inReady;
   assign load1   = xfer & (select == SEL_OUT1);
   assign load2   = xfer & (select == SEL_OUT2);

   out_slot_16 #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_slot1 (
      .clk      (clk),
      .reset    (reset),
      .load     (load1),
      .din      (myIn),
      .can_take (take1),
      .data     (myOut1),
      .valid    (out1Valid),
      .ready    (out1Ready),
      .count    (count1)
   );

   out_slot_16 #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_slot2 (
      .clk      (clk),
      .reset    (reset),
      .load     (load2),
      .din      (myIn),
      .can_take (take2),
      .data     (myOut2),
      .valid    (out2Valid),
      .ready    (out2Ready),
      .count    (count2)
   );

endmodule

// File: tb/tb_demultiplexer_16_reg.sv
// Scoreboard bench for demultiplexer_16_reg: a negedge monitor
// models both slots, and per-scenario tasks add direct checks.
module tb_demultiplexer_16_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] myIn = '0;
   logic        select = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [15:0] myOut1;
   logic        out1Valid;
   logic        out1Ready = 1'b0;
   logic [15:0] myOut2;
   logic        out2Valid;
   logic        out2Ready = 1'b0;
   logic [7:0]  count1;
   logic [7:0]  count2;

   int tests = 0;
   int failed = 0;
   bit mon_en = 1'b0;

   logic [15:0] q1[$];
   logic [15:0] q2[$];
   logic        mv1, mv2;
   logic [7:0]  mc1, mc2;
   logic        exp_rdy;

   demultiplexer_16_reg dut (
      .clk       (clk),
      .reset     (reset),
      .myIn      (myIn),
      .select    (select),
      .inValid   (inValid),
      .inReady   (inReady),
      .myOut1    (myOut1),
      .out1Valid (out1Valid),
      .out1Ready (out1Ready),
      .myOut2    (myOut2),
      .out2Valid (out2Valid),
      .out2Ready (out2Ready),
      .count1    (count1),
      .count2    (count2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: compare state, then advance to the next edge.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_rdy = select ? (!mv2 || out2Ready)
                          : (!mv1 || out1Ready);
         tests++;
         if (inReady !== exp_rdy) begin
            failed++;
            $display("FAIL mon_inReady got %b want %b t=%0t",
                     inReady, exp_rdy, $time);
         end
         tests++;
         if (out1Valid !== mv1 || out2Valid !== mv2) begin
            failed++;
            $display("FAIL mon_valid got %b%b want %b%b t=%0t",
                     out1Valid, out2Valid, mv1, mv2, $time);
         end
         tests++;
         if (count1 !== mc1 || count2 !== mc2) begin
            failed++;
            $display("FAIL mon_count got %0d/%0d want %0d/%0d t=%0t",
                     count1, count2, mc1, mc2, $time);
         end
         if (mv1 && q1.size() > 0) begin
            tests++;
            if (myOut1 !== q1[0]) begin
               failed++;
               $display("FAIL mon_out1 got %0d want %0d t=%0t",
                        myOut1, q1[0], $time);
            end
         end
         if (mv2 && q2.size() > 0) begin
            tests++;
            if (myOut2 !== q2[0]) begin
               failed++;
               $display("FAIL mon_out2 got %0d want %0d t=%0t",
                        myOut2, q2[0], $time);
            end
         end
         if (reset) begin
            q1.delete();
            q2.delete();
            mv1 = 1'b0;
            mv2 = 1'b0;
            mc1 = '0;
            mc2 = '0;
         end else begin
            if (mv1 && out1Ready) begin
               if (q1.size() > 0) void'(q1.pop_front());
               mc1 = mc1 + 8'd1;
               mv1 = 1'b0;
            end
            if (mv2 && out2Ready) begin
               if (q2.size() > 0) void'(q2.pop_front());
               mc2 = mc2 + 8'd1;
               mv2 = 1'b0;
            end
            if (inValid && exp_rdy) begin
               if (select) begin
                  q2.push_back(myIn);
                  mv2 = 1'b1;
               end else begin
                  q1.push_back(myIn);
                  mv1 = 1'b1;
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tests++;
      if (myOut1 !== 16'd0 || myOut2 !== 16'd0) begin
         failed++;
         $display("FAIL reset_data got %0d/%0d want 0/0",
                  myOut1, myOut2);
      end
      tests++;
      if (out1Valid !== 1'b0 || out2Valid !== 1'b0) begin
         failed++;
         $display("FAIL reset_valid got %b%b want 00",
                  out1Valid, out2Valid);
      end
      tests++;
      if (count1 !== 8'd0 || count2 !== 8'd0) begin
         failed++;
         $display("FAIL reset_count got %0d/%0d want 0/0",
                  count1, count2);
      end
      select = 1'b0;
      #1;
      tests++;
      if (inReady !== 1'b1) begin
         failed++;
         $display("FAIL reset_rdy0 got %b want 1", inReady);
      end
      select = 1'b1;
      #1;
      tests++;
      if (inReady !== 1'b1) begin
         failed++;
         $display("FAIL reset_rdy1 got %b want 1", inReady);
      end
      select = 1'b0;
      q1.delete();
      q2.delete();
      mv1 = 1'b0;
      mv2 = 1'b0;
      mc1 = '0;
      mc2 = '0;
      mon_en = 1'b1;
   endtask

   task automatic test_route();
      myIn = 16'd256;
      select = 1'b0;
      inValid = 1'b1;
      out1Ready = 1'b1;
      tick();
      inValid = 1'b0;
      tests++;
      if (myOut1 !== 16'd256 || out1Valid !== 1'b1) begin
         failed++;
         $display("FAIL route1_load got %0d v=%b want 256 v=1",
                  myOut1, out1Valid);
      end
      tests++;
      if (out2Valid !== 1'b0 || myOut2 !== 16'd0) begin
         failed++;
         $display("FAIL route1_slot2 got %0d v=%b want 0 v=0",
                  myOut2, out2Valid);
      end
      tick();
      tests++;
      if (count1 !== 8'd1 || out1Valid !== 1'b0) begin
         failed++;
         $display("FAIL route1_count got %0d v=%b want 1 v=0",
                  count1, out1Valid);
      end
      myIn = 16'd1024;
      select = 1'b1;
      inValid = 1'b1;
      out2Ready = 1'b1;
      tick();
      inValid = 1'b0;
      tests++;
      if (myOut2 !== 16'd1024 || out2Valid !== 1'b1) begin
         failed++;
         $display("FAIL route2_load got %0d v=%b want 1024 v=1",
                  myOut2, out2Valid);
      end
      tick();
      tests++;
      if (count2 !== 8'd1 || count1 !== 8'd1) begin
         failed++;
         $display("FAIL route2_count got %0d/%0d want 1/1",
                  count1, count2);
      end
      out1Ready = 1'b0;
      out2Ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [7:0] b1;
      b1 = count1;
      myIn = 16'd256;
      select = 1'b0;
      inValid = 1'b1;
      tick();
      myIn = 16'd1024;
      select = 1'b1;
      tick();
      tests++;
      if (myOut2 !== 16'd1024 || out2Valid !== 1'b1) begin
         failed++;
         $display("FAIL bp_slot2 got %0d v=%b want 1024 v=1",
                  myOut2, out2Valid);
      end
      myIn = 16'd512;
      select = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests++;
         if (inReady !== 1'b0) begin
            failed++;
            $display("FAIL bp_rdy got %b want 0 cyc=%0d", inReady, i);
         end
         tests++;
         if (myOut1 !== 16'd256) begin
            failed++;
            $display("FAIL bp_hold got %0d want 256 cyc=%0d",
                     myOut1, i);
         end
         tick();
      end
      out1Ready = 1'b1;
      #1;
      tests++;
      if (inReady !== 1'b1) begin
         failed++;
         $display("FAIL bp_rdy_up got %b want 1", inReady);
      end
      tick();
      inValid = 1'b0;
      tests++;
      if (myOut1 !== 16'd512 || out1Valid !== 1'b1
          || count1 !== b1 + 8'd1) begin
         failed++;
         $display("FAIL bp_refill got %0d v=%b c=%0d want 512 v=1 c=%0d",
                  myOut1, out1Valid, count1, b1 + 8'd1);
      end
      tick();
      tests++;
      if (count1 !== b1 + 8'd2 || out1Valid !== 1'b0) begin
         failed++;
         $display("FAIL bp_drain got %0d v=%b want %0d v=0",
                  count1, out1Valid, b1 + 8'd2);
      end
      out2Ready = 1'b1;
      tick();
      out1Ready = 1'b0;
      out2Ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] b1;
      b1 = count1;
      out1Ready = 1'b1;
      select = 1'b0;
      inValid = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         myIn = 16'(i);
         #1;
         tests++;
         if (inReady !== 1'b1) begin
            failed++;
            $display("FAIL stream_bubble got %b want 1 word=%0d",
                     inReady, i);
         end
         tick();
      end
      inValid = 1'b0;
      tick();
      tests++;
      if (count1 !== b1 + 8'd10) begin
         failed++;
         $display("FAIL stream_count got %0d want %0d",
                  count1, b1 + 8'd10);
      end
      out1Ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] b1;
      logic [7:0] b2;
      b1 = count1;
      b2 = count2;
      out2Ready = 1'b1;
      select = 1'b1;
      inValid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         myIn = 16'(i * 3 + 7);
         tick();
      end
      inValid = 1'b0;
      tick();
      tests++;
      if (count2 !== b2) begin
         failed++;
         $display("FAIL wrap_count2 got %0d want %0d", count2, b2);
      end
      tests++;
      if (count1 !== b1) begin
         failed++;
         $display("FAIL wrap_count1 got %0d want %0d", count1, b1);
      end
      out2Ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      myIn = 16'hA5A5;
      select = 1'b0;
      inValid = 1'b1;
      tick();
      myIn = 16'h5A5A;
      select = 1'b1;
      tick();
      tests++;
      if (out1Valid !== 1'b1 || out2Valid !== 1'b1) begin
         failed++;
         $display("FAIL rmid_full got %b%b want 11",
                  out1Valid, out2Valid);
      end
      myIn = 16'h1234;
      select = 1'b0;
      out1Ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      inValid = 1'b0;
      out1Ready = 1'b0;
      tests++;
      if (out1Valid !== 1'b0 || out2Valid !== 1'b0) begin
         failed++;
         $display("FAIL rmid_valid got %b%b want 00",
                  out1Valid, out2Valid);
      end
      tests++;
      if (myOut1 !== 16'd0 || myOut2 !== 16'd0) begin
         failed++;
         $display("FAIL rmid_data got %0d/%0d want 0/0",
                  myOut1, myOut2);
      end
      tests++;
      if (count1 !== 8'd0 || count2 !== 8'd0) begin
         failed++;
         $display("FAIL rmid_count got %0d/%0d want 0/0",
                  count1, count2);
      end
      tick();
   endtask

   initial begin
      mv1 = 1'b0;
      mv2 = 1'b0;
      mc1 = '0;
      mc2 = '0;
      test_reset();
      test_route();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
